// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared types and constants for the frequency monitor
package freq_pkg;

    typedef enum logic [1:0] {
        ACQ   = 2'b00,
        LOCK  = 2'b01,
        ALARM = 2'b10
    } freq_state_t;

    localparam logic [15:0] FREQ_LO_DEF = 16'd1000;
    localparam logic [15:0] FREQ_HI_DEF = 16'd2000;
    localparam int          ALARM_CNT_W = 8;

endpackage

// File: rtl/freq_avg_acc.sv
// rtl/freq_avg_acc.sv - accumulate 2^AVG_LOG2 freq/phase samples and emit their truncated mean
module freq_avg_acc #(
    parameter int DSIZE    = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [DSIZE-1:0] in_freq,
    input  logic [DSIZE-1:0] in_phase,
    output logic [DSIZE-1:0] avg_freq,
    output logic [DSIZE-1:0] avg_phase,
    output logic             avg_valid
);

    // Sum is wide enough for 2^AVG_LOG2 full-scale samples, so it can never overflow.
    localparam int ACC_W = DSIZE + AVG_LOG2;
    // A zero-width counter is not legal; with no averaging the 1-bit counter just stays at 0.
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_freq;
    logic [ACC_W-1:0] acc_phase;
    logic [CNT_W-1:0] cnt;

    // Accumulate samples; the completing sample folds into the sum, which is shifted out as the mean.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc_freq  <= '0;
            acc_phase <= '0;
            cnt       <= '0;
            avg_freq  <= '0;
            avg_phase <= '0;
            avg_valid <= 1'b0;
        end else if (clear) begin
            acc_freq  <= '0;
            acc_phase <= '0;
            cnt       <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (in_valid) begin
                if (cnt == LAST) begin
                    avg_freq  <= DSIZE'((acc_freq + ACC_W'(in_freq)) >> AVG_LOG2);
                    avg_phase <= DSIZE'((acc_phase + ACC_W'(in_phase)) >> AVG_LOG2);
                    avg_valid <= 1'b1;
                    acc_freq  <= '0;
                    acc_phase <= '0;
                    cnt       <= '0;
                end else begin
                    acc_freq  <= acc_freq + ACC_W'(in_freq);
                    acc_phase <= acc_phase + ACC_W'(in_phase);
                    cnt       <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/freq_monitor.sv
// rtl/freq_monitor.sv - averaged frequency band check with lock/alarm hysteresis FSM
module freq_monitor
    import freq_pkg::*;
#(
    parameter int               DSIZE    = 16,
    parameter int               AVG_LOG2 = 2,
    parameter logic [DSIZE-1:0] FREQ_LO  = DSIZE'(FREQ_LO_DEF),
    parameter logic [DSIZE-1:0] FREQ_HI  = DSIZE'(FREQ_HI_DEF),
    parameter int               HOLD_CNT = 3
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   meas_valid,
    input  logic [DSIZE-1:0]       freq,
    input  logic [DSIZE-1:0]       phase,
    input  logic                   cfg_clear,
    output logic [DSIZE-1:0]       avg_freq,
    output logic [DSIZE-1:0]       avg_phase,
    output logic                   avg_valid,
    output logic                   in_range,
    output logic                   lock,
    output logic                   alarm,
    output logic [ALARM_CNT_W-1:0] alarm_cnt,
    output logic [1:0]             state
);

    localparam logic [3:0] HOLD = 4'(HOLD_CNT);

    freq_state_t            state_q, state_d;
    logic [3:0]             hyst_q, hyst_d, hyst_inc;
    logic [ALARM_CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
    logic                   in_range_q;
    logic                   eval_q;
    logic                   range_ok;

    freq_avg_acc #(
        .DSIZE    (DSIZE),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clock     (clock),
        .rst_n     (rst_n),
        .clear     (cfg_clear),
        .in_valid  (meas_valid),
        .in_freq   (freq),
        .in_phase  (phase),
        .avg_freq  (avg_freq),
        .avg_phase (avg_phase),
        .avg_valid (avg_valid)
    );

    assign range_ok = (avg_freq >= FREQ_LO) && (avg_freq <= FREQ_HI) && (avg_freq != '0);
    assign hyst_inc = hyst_q + 4'd1;

    // Next-state logic: one hysteresis step per average, taken the cycle after avg_valid.
    always_comb begin
        state_d     = state_q;
        hyst_d      = hyst_q;
        alarm_cnt_d = alarm_cnt_q;
        case (state_q)
            ACQ, ALARM: begin
                if (eval_q) begin
                    if (in_range_q) begin
                        if (hyst_inc == HOLD) begin
                            state_d = LOCK;
                            hyst_d  = 4'd0;
                        end else begin
                            hyst_d = hyst_inc;
                        end
                    end else begin
                        hyst_d = 4'd0;
                    end
                end
            end
            LOCK: begin
                if (eval_q) begin
                    if (!in_range_q) begin
                        if (hyst_inc == HOLD) begin
                            state_d = ALARM;
                            hyst_d  = 4'd0;
                            if (alarm_cnt_q != '1) begin
                                alarm_cnt_d = alarm_cnt_q + ALARM_CNT_W'(1);
                            end
                        end else begin
                            hyst_d = hyst_inc;
                        end
                    end else begin
                        hyst_d = 4'd0;
                    end
                end
            end
            default: begin
                state_d = ACQ;
                hyst_d  = 4'd0;
            end
        endcase
    end

    // State, hysteresis, alarm counter and range flag; cfg_clear restarts all but the alarm count.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACQ;
            hyst_q      <= 4'd0;
            alarm_cnt_q <= '0;
            in_range_q  <= 1'b0;
            eval_q      <= 1'b0;
        end else if (cfg_clear) begin
            state_q    <= ACQ;
            hyst_q     <= 4'd0;
            in_range_q <= 1'b0;
            eval_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hyst_q      <= hyst_d;
            alarm_cnt_q <= alarm_cnt_d;
            eval_q      <= avg_valid;
            if (avg_valid) begin
                in_range_q <= range_ok;
            end
        end
    end

    assign in_range  = in_range_q;
    assign lock      = (state_q == LOCK);
    assign alarm     = (state_q == ALARM);
    assign alarm_cnt = alarm_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_freq_monitor.sv
// tb/tb_freq_monitor.sv - self-checking bench for freq_monitor
module tb_freq_monitor;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        meas_valid = 1'b0;
    logic [15:0] freq = '0;
    logic [15:0] phase = '0;
    logic        cfg_clear = 1'b0;
    logic [15:0] avg_freq, avg_phase;
    logic        avg_valid, in_range, lock, alarm;
    logic [7:0]  alarm_cnt;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    typedef struct packed {
        logic [3:0][15:0] f;
        logic [3:0][15:0] p;
        logic [15:0]      ef;
        logic [15:0]      ep;
        logic             eir;
    } vec_t;

    vec_t vecs[8];

    freq_monitor dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .meas_valid (meas_valid),
        .freq       (freq),
        .phase      (phase),
        .cfg_clear  (cfg_clear),
        .avg_freq   (avg_freq),
        .avg_phase  (avg_phase),
        .avg_valid  (avg_valid),
        .in_range   (in_range),
        .lock       (lock),
        .alarm      (alarm),
        .alarm_cnt  (alarm_cnt),
        .state      (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each avg_valid pulse must match the oldest pushed expectation.
    always @(negedge clock) begin
        if (rst_n && avg_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_avg_valid", 64'd1, 64'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("avg_freq", 64'(avg_freq), 64'(e[31:16]));
                check("avg_phase", 64'(avg_phase), 64'(e[15:0]));
            end
        end
    end

    task automatic send_window(input logic [3:0][15:0] f, input logic [3:0][15:0] p,
                               input logic [15:0] ef, input logic [15:0] ep, input bit clr_last);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            meas_valid = 1'b1;
            freq       = f[i];
            phase      = p[i];
            if (i == 3) begin
                cfg_clear = clr_last;
                if (!clr_last) exp_q.push_back({ef, ep});
            end
        end
        @(negedge clock);
        meas_valid = 1'b0;
        cfg_clear  = 1'b0;
        check("avg_valid_latency", 64'(avg_valid), 64'(!clr_last));
    endtask

    task automatic send_const(input logic [15:0] f);
        send_window({4{f}}, {4{16'd100}}, f, 16'd100, 1'b0);
    endtask

    task automatic wait_fsm();
        repeat (2) @(negedge clock);
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        cfg_clear = 1'b1;
        @(negedge clock);
        cfg_clear = 1'b0;
    endtask

    initial begin
        vecs[0] = '{f: {16'd1300, 16'd1200, 16'd1100, 16'd1000}, p: {16'd502, 16'd500, 16'd500, 16'd500},
                    ef: 16'd1150, ep: 16'd500, eir: 1'b1};
        vecs[1] = '{f: {16'd2, 16'd1, 16'd1, 16'd1}, p: {16'd3, 16'd0, 16'd0, 16'd0},
                    ef: 16'd1, ep: 16'd0, eir: 1'b0};
        vecs[2] = '{f: {16'd1000, 16'd1000, 16'd1000, 16'd999}, p: {4{16'd7}},
                    ef: 16'd999, ep: 16'd7, eir: 1'b0};
        vecs[3] = '{f: {4{16'd1000}}, p: {16'd4, 16'd3, 16'd2, 16'd1},
                    ef: 16'd1000, ep: 16'd2, eir: 1'b1};
        vecs[4] = '{f: {16'd2003, 16'd2000, 16'd2000, 16'd2000}, p: {4{16'd900}},
                    ef: 16'd2000, ep: 16'd900, eir: 1'b1};
        vecs[5] = '{f: {4{16'd65535}}, p: {4{16'd65535}},
                    ef: 16'd65535, ep: 16'd65535, eir: 1'b0};
        vecs[6] = '{f: {4{16'd0}}, p: {4{16'd0}},
                    ef: 16'd0, ep: 16'd0, eir: 1'b0};
        vecs[7] = '{f: {4{16'd2001}}, p: {4{16'd1}},
                    ef: 16'd2001, ep: 16'd1, eir: 1'b0};

        repeat (2) @(negedge clock);
        check("reset_outputs", {avg_freq, avg_phase, 8'(alarm_cnt), 6'(state), avg_valid, in_range, lock, alarm}, 64'd0);
        rst_n = 1'b1;
        @(negedge clock);

        // Averaging, truncation and band boundaries.
        foreach (vecs[k]) begin
            send_window(vecs[k].f, vecs[k].p, vecs[k].ef, vecs[k].ep, 1'b0);
            @(negedge clock);
            check($sformatf("in_range_vec%0d", k), 64'(in_range), 64'(vecs[k].eir));
        end

        pulse_clear();
        check("clear_state", 64'(state), 64'd0);
        check("clear_in_range", 64'(in_range), 64'd0);
        check("clear_keeps_avg", 64'(avg_freq), 64'd2001);

        // Clear during the evaluation cycle discards the pending step.
        send_const(16'd1500); wait_fsm();
        send_const(16'd1500); wait_fsm();
        send_const(16'd1500);
        @(negedge clock);
        cfg_clear = 1'b1;
        @(negedge clock);
        cfg_clear = 1'b0;
        check("pending_discarded", 64'(state), 64'd0);

        // Three in-range averages to lock.
        send_const(16'd1500); wait_fsm();
        check("acq_after_1", 64'(state), 64'd0);
        send_const(16'd1500); wait_fsm();
        check("acq_after_2", 64'(state), 64'd0);
        send_const(16'd1500);
        @(negedge clock);
        check("lock_not_yet", 64'(lock), 64'd0);
        @(negedge clock);
        check("lock_rise", {lock, 6'd0, state}, {1'b1, 6'd0, 2'b01});

        // Interrupted run of bad averages does not alarm; an unbroken run does.
        send_const(16'd2500);
        send_const(16'd2500);
        send_const(16'd1500); wait_fsm();
        check("no_alarm_yet", {alarm, 6'd0, state}, {1'b0, 6'd0, 2'b01});
        send_const(16'd0);
        send_const(16'd0); wait_fsm();
        check("still_lock", 64'(state), 64'd1);
        send_const(16'd0); wait_fsm();
        check("alarm_set", {alarm, alarm_cnt, 6'd0, state}, {1'b1, 8'd1, 6'd0, 2'b10});

        // Clear with the completing sample drops the window.
        send_const(16'd1200);
        send_window({4{16'd1300}}, {4{16'd100}}, 16'd0, 16'd0, 1'b1);
        check("drop_state", 64'(state), 64'd0);
        check("drop_avg_kept", 64'(avg_freq), 64'd1200);
        check("drop_cnt_kept", 64'(alarm_cnt), 64'd1);
        send_const(16'd1200); wait_fsm();
        check("after_drop_avg", 64'(avg_freq), 64'd1200);

        // Build up to alarm_cnt=5 in ALARM, then reset asynchronously.
        send_const(16'd1500); send_const(16'd1500); send_const(16'd1500); wait_fsm();
        check("relock", 64'(state), 64'd1);
        for (int k = 2; k <= 5; k++) begin
            send_const(16'd0); send_const(16'd0); send_const(16'd0);
            if (k < 5) begin
                send_const(16'd1500); send_const(16'd1500); send_const(16'd1500);
            end
        end
        wait_fsm();
        check("pre_reset", {alarm_cnt, 6'd0, state}, {8'd5, 6'd0, 2'b10});
        #2 rst_n = 1'b0;
        #1 check("async_reset", {avg_freq, avg_phase, 8'(alarm_cnt), 6'(state), avg_valid, in_range, lock, alarm}, 64'd0);
        @(negedge clock);
        rst_n = 1'b1;
        repeat (3) @(negedge clock);
        check("post_reset", {avg_freq, avg_phase, 8'(alarm_cnt), 6'(state), avg_valid, in_range, lock, alarm}, 64'd0);

        // Alarm counter saturates at 255.
        for (int k = 1; k <= 256; k++) begin
            send_const(16'd1500); send_const(16'd1500); send_const(16'd1500);
            send_const(16'd0); send_const(16'd0); send_const(16'd0);
            wait_fsm();
            if (k >= 254) check($sformatf("alarm_cnt_%0d", k), 64'(alarm_cnt), 64'((k > 255) ? 255 : k));
        end
        check("sat_state", 64'(state), 64'd2);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
